// File: rtl/uio_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uio_arb_pkg - shared types/constants for the uio pad-bank arbiter  rev 1.0|
// +--------------------------------------------------------------------------+
package uio_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TURN = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic       DIR_READ  = 1'b0;
  localparam logic       DIR_WRITE = 1'b1;
  localparam logic [7:0] OE_IN     = 8'h00;
  localparam logic [7:0] OE_OUT    = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/uio_rr_picker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uio_rr_picker - one-hot request picker; UIO_ARB_FIXED_PRIO_EN = fixed prio|
// +--------------------------------------------------------------------------+
module uio_rr_picker #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] win_o,
  output logic             valid_o
);

`ifdef UIO_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  logic found;
  assign unused_ptr = ^ptr_i;

  always_comb begin
    win_o = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req_i[k]) begin
        win_o[k] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`else
  logic [IDX_W:0] pos;
  logic           found;

  // Scan from the pointer upwards, wrapping modulo N_REQ.
  always_comb begin
    win_o = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      pos = {1'b0, ptr_i} + (IDX_W+1)'(k);
      if (pos >= (IDX_W+1)'(N_REQ)) pos = pos - (IDX_W+1)'(N_REQ);
      if (!found && req_i[pos[IDX_W-1:0]]) begin
        win_o[pos[IDX_W-1:0]] = 1'b1;
        found                 = 1'b1;
      end
    end
  end
`endif

  assign valid_o = found;

endmodule
`default_nettype wire

// File: rtl/uio_bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uio_bus_arbiter - shares uio pads among N_REQ requesters with turnaround. |
// | UIO_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin. r1.0 |
// +--------------------------------------------------------------------------+
module uio_bus_arbiter
  import uio_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int HOLD_CYCLES = 2,
  parameter int TURN_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   dir,
  input  logic [8*N_REQ-1:0] wdata,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done,
  output logic [7:0]         rdata,
  output logic               busy,
  input  logic [7:0]         uio_in,
  output logic [7:0]         uio_out,
  output logic [7:0]         uio_oe
);

  localparam int IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_MAX = (HOLD_CYCLES > TURN_CYCLES) ? HOLD_CYCLES : TURN_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t             state_q;
  logic [N_REQ-1:0]   gnt_q;
  logic [N_REQ-1:0]   done_q;
  logic [7:0]         rdata_q;
  logic               busy_q;
  logic [7:0]         uio_out_q;
  logic [7:0]         uio_oe_q;
  logic [IDX_W-1:0]   idx_q;
  logic               dir_q;
  logic [7:0]         wdata_q;
  logic               last_dir_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   ptr;

  logic [N_REQ-1:0]   pick_win;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_dir;
  logic [7:0]         pick_wdata;

`ifdef UIO_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [IDX_W-1:0]   ptr_q;
  assign ptr = ptr_q;
`endif

  uio_rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req_i   (req),
    .ptr_i   (ptr),
    .win_o   (pick_win),
    .valid_o (pick_valid)
  );

  always_comb begin
    pick_idx   = '0;
    pick_dir   = DIR_READ;
    pick_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_win[i]) begin
        pick_idx   = IDX_W'(i);
        pick_dir   = dir[i];
        pick_wdata = wdata[8*i +: 8];
      end
    end
  end

  // Pad outputs are registered alongside the state, so each transition loads
  // the values the destination state presents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      done_q     <= '0;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
      uio_out_q  <= '0;
      uio_oe_q   <= OE_IN;
      idx_q      <= '0;
      dir_q      <= DIR_READ;
      wdata_q    <= '0;
      last_dir_q <= DIR_READ;
      cnt_q      <= '0;
`ifndef UIO_ARB_FIXED_PRIO_EN
      ptr_q      <= '0;
`endif
    end else begin
      done_q <= '0;
      case (state_q)
        IDLE: begin
          if (ena && pick_valid) begin
            idx_q   <= pick_idx;
            dir_q   <= pick_dir;
            wdata_q <= pick_wdata;
            gnt_q   <= pick_win;
            busy_q  <= 1'b1;
            if (pick_dir != last_dir_q) begin
              state_q   <= TURN;
              cnt_q     <= CNT_W'(TURN_CYCLES - 1);
              uio_oe_q  <= OE_IN;
              uio_out_q <= '0;
            end else begin
              state_q   <= XFER;
              cnt_q     <= CNT_W'(HOLD_CYCLES - 1);
              uio_oe_q  <= (pick_dir == DIR_WRITE) ? OE_OUT : OE_IN;
              uio_out_q <= (pick_dir == DIR_WRITE) ? pick_wdata : 8'h00;
            end
          end
        end
        TURN: begin
          if (cnt_q == '0) begin
            last_dir_q <= dir_q;
            state_q    <= XFER;
            cnt_q      <= CNT_W'(HOLD_CYCLES - 1);
            uio_oe_q   <= (dir_q == DIR_WRITE) ? OE_OUT : OE_IN;
            uio_out_q  <= (dir_q == DIR_WRITE) ? wdata_q : 8'h00;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        XFER: begin
          if (cnt_q == '0) begin
            if (dir_q == DIR_READ) rdata_q <= uio_in;
            state_q       <= DONE;
            gnt_q         <= '0;
            done_q[idx_q] <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
`ifndef UIO_ARB_FIXED_PRIO_EN
          ptr_q   <= (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + IDX_W'(1);
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign rdata   = rdata_q;
  assign busy    = busy_q;
  assign uio_out = uio_out_q;
  assign uio_oe  = uio_oe_q;

endmodule
`default_nettype wire

// File: tb/tb_uio_bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uio_bus_arbiter - scoreboard bench for uio_bus_arbiter (N_REQ=4). r1.0 |
// +--------------------------------------------------------------------------+
module tb_uio_bus_arbiter;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic [3:0]  req;
  logic [3:0]  dir;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic [7:0]  rdata;
  logic        busy;
  logic [7:0]  uio_in;
  logic [7:0]  uio_out;
  logic [7:0]  uio_oe;

  typedef struct {
    logic [3:0] owner;
    logic       rd;
    logic [7:0] rval;
  } exp_t;

  exp_t       sbq[$];
  exp_t       sb_e;
  int         n_cmp = 0;
  int         n_err = 0;
  logic [3:0] ord[5];
  logic [3:0] t5_win;

  uio_bus_arbiter #(
    .N_REQ       (4),
    .HOLD_CYCLES (2),
    .TURN_CYCLES (1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .req     (req),
    .dir     (dir),
    .wdata   (wdata),
    .gnt     (gnt),
    .done    (done),
    .rdata   (rdata),
    .busy    (busy),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] owner, input logic rd, input logic [7:0] rval);
    exp_t e;
    e.owner = owner;
    e.rd    = rd;
    e.rval  = rval;
    sbq.push_back(e);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Completion monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done !== 4'b0000) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_unexpected_done: got done=%b, required no pulse", done);
      end else begin
        sb_e = sbq.pop_front();
        check("sb_done_owner", 32'(done), 32'(sb_e.owner));
        if (sb_e.rd) check("sb_rdata", 32'(rdata), 32'(sb_e.rval));
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k;
    logic [3:0] prev;
`ifdef UIO_ARB_FIXED_PRIO_EN
    ord    = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    t5_win = 4'b0001;
`else
    ord    = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    t5_win = 4'b0010;
`endif
    rst_n = 1'b0; ena = 1'b0; req = '0; dir = '0; wdata = '0; uio_in = '0;
    repeat (3) cyc();
    check("rst_gnt",   32'(gnt),     32'h0);
    check("rst_done",  32'(done),    32'h0);
    check("rst_rdata", 32'(rdata),   32'h0);
    check("rst_busy",  32'(busy),    32'h0);
    check("rst_out",   32'(uio_out), 32'h0);
    check("rst_oe",    32'(uio_oe),  32'h0);
    rst_n = 1'b1;
    cyc();

    // Write from reset: read->write turnaround first.
    ena = 1'b1; req = 4'b0010; dir = 4'b0010; wdata = 32'h0000_A500;
    push(4'b0010, 1'b0, 8'h00);
    cyc();
    check("w_t1_gnt",  32'(gnt),    32'h2);
    check("w_t1_oe",   32'(uio_oe), 32'h00);
    check("w_t1_busy", 32'(busy),   32'h1);
    req = '0; dir = '0; wdata = '0;
    cyc();
    check("w_t2_oe",  32'(uio_oe),  32'hFF);
    check("w_t2_out", 32'(uio_out), 32'hA5);
    cyc();
    check("w_t3_oe",  32'(uio_oe),  32'hFF);
    check("w_t3_out", 32'(uio_out), 32'hA5);
    cyc();
    check("w_t4_done", 32'(done), 32'h2);
    check("w_t4_gnt",  32'(gnt),  32'h0);
    cyc();
    check("w_park_oe",   32'(uio_oe),  32'hFF);
    check("w_park_out",  32'(uio_out), 32'hA5);
    check("w_park_busy", 32'(busy),    32'h0);

    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;

    // Read from reset: no turnaround, sampled on the final XFER cycle.
    req = 4'b0001; dir = 4'b0000; uio_in = 8'h11;
    push(4'b0001, 1'b1, 8'h3C);
    cyc();
    check("r_t1_gnt", 32'(gnt),    32'h1);
    check("r_t1_oe",  32'(uio_oe), 32'h00);
    req = '0;
    cyc();
    uio_in = 8'h3C;
    check("r_t2_oe", 32'(uio_oe), 32'h00);
    cyc();
    check("r_t3_done", 32'(done), 32'h1);
    uio_in = 8'h77;
    cyc();
    check("r_hold_rdata", 32'(rdata), 32'h3C);
    check("r_idle_busy",  32'(busy),  32'h0);

    // Write then read: turnaround back to input before sampling.
    req = 4'b0100; dir = 4'b0100; wdata = 32'h005A_0000;
    push(4'b0100, 1'b0, 8'h00);
    cyc();
    check("wr_t1_gnt", 32'(gnt),    32'h4);
    check("wr_t1_oe",  32'(uio_oe), 32'h00);
    req = '0;
    cyc();
    check("wr_t2_out", 32'(uio_out), 32'h5A);
    cyc();
    cyc();
    req = 4'b1000; dir = 4'b0000; uio_in = 8'hC3;
    push(4'b1000, 1'b1, 8'hC3);
    cyc();
    check("wr_t5_park_oe", 32'(uio_oe), 32'hFF);
    cyc();
    check("rd_t6_gnt", 32'(gnt),     32'h8);
    check("rd_t6_oe",  32'(uio_oe),  32'h00);
    check("rd_t6_out", 32'(uio_out), 32'h00);
    req = '0;
    cyc();
    cyc();
    cyc();
    check("rd_t9_done", 32'(done), 32'h8);

    // Contention: all four requesting reads continuously.
    req = 4'b1111; dir = 4'b0000; uio_in = 8'h99;
    k = 0; prev = '0;
    for (int c = 0; c < 40 && k < 5; c++) begin
      cyc();
      if (gnt != 4'b0000 && prev == 4'b0000) begin
        check("rr_order", 32'(gnt), 32'(ord[k]));
        push(ord[k], 1'b1, 8'h99);
        k++;
        if (k == 5) req = '0;
      end
      prev = gnt;
    end
    check("rr_grants_seen", 32'(k), 32'd5);
    repeat (5) cyc();

    // ena low blocks new grants.
    ena = 1'b0; req = 4'b0001;
    repeat (4) cyc();
    check("ena0_gnt",  32'(gnt),  32'h0);
    check("ena0_busy", 32'(busy), 32'h0);
    ena = 1'b1; req = 4'b0011;
    push(t5_win, 1'b1, 8'h99);
    cyc();
    check("ena_t1_gnt", 32'(gnt), 32'(t5_win));
    cyc();
    ena = 1'b0;
    cyc();
    check("ena_t3_done", 32'(done), 32'(t5_win));
    repeat (6) cyc();
    check("ena_off_gnt",  32'(gnt),  32'h0);
    check("ena_off_busy", 32'(busy), 32'h0);
    req = '0; ena = 1'b1;
    cyc();

    // Asynchronous reset in the middle of a write XFER.
    req = 4'b0100; dir = 4'b0100; wdata = 32'h00E7_0000;
    cyc();
    check("ar_t1_gnt", 32'(gnt), 32'h4);
    req = '0;
    cyc();
    check("ar_t2_oe", 32'(uio_oe), 32'hFF);
    #1 rst_n = 1'b0;
    #1;
    check("ar_oe",   32'(uio_oe),  32'h00);
    check("ar_gnt",  32'(gnt),     32'h0);
    check("ar_busy", 32'(busy),    32'h0);
    check("ar_out",  32'(uio_out), 32'h00);
    cyc();
    cyc();
    rst_n = 1'b1;
    req = 4'b1111; dir = 4'b0000; uio_in = 8'h55;
    push(4'b0001, 1'b1, 8'h55);
    cyc();
    check("ar_next_gnt", 32'(gnt), 32'h1);
    req = '0;
    repeat (4) cyc();
    check("sb_all_done", 32'(sbq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
